uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Controller that sits directly behind the UART receiver and sequences its single-cycle byte strobes into a downstream stream interface. It buffers received bytes in a small FIFO and exposes them over a valid/ready handshake. It flags overflow when the consumer stalls. It detects end-of-message by timing line idleness (no new byte for TIMEOUT_CYC clocks). It is the only consumer of the receiver's RxData/valid_rx pair.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2.
DATA_W, 8, byte width; must match the receiver's RxData.
TIMEOUT_CYC, 4340, idle clocks after the last byte before end-of-message (10 bit-times at 50 MHz / 115200).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle byte strobe from the receiver
rx_data  in  DATA_W  received byte; qualified by rx_valid
m_valid  out  1  FIFO head is valid
m_data  out  DATA_W  FIFO head byte
m_ready  in  1  consumer accepts the head byte
eom  out  1  one-cycle end-of-message pulse
idle  out  1  no message in progress
overflow  out  1  sticky flag: a byte was dropped
clr_overflow  in  1  clears overflow
level  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - m_valid=0, level=0, eom=0, overflow=0, idle=1, m_data=0.
  - Pointers, count and timer are cleared.
  - Reset mid-message discards all buffered bytes and any pending eom.
- FIFO (first-word fall-through):
  - m_valid = (level != 0).
  - m_data = mem[rd_ptr], driven straight from registers.
  - Pop = m_valid & m_ready.
  - Push = rx_valid & (level < DEPTH | pop).
  - A byte strobed at edge N is visible on m_valid/m_data after edge N. Latency is 1 cycle.
  - Pointers wrap modulo DEPTH.
  - level: +1 on push only, -1 on pop only, unchanged on both or neither.
  - Push while full with a same-cycle pop is accepted; level stays DEPTH and order is preserved.
  - m_ready while empty has no effect.
- Overflow:
  - rx_valid with level==DEPTH and no pop: byte is dropped and overflow is set.
  - overflow holds until clr_overflow.
  - A set and a clear in the same cycle leave overflow=1.
- Message-timeout FSM, states IDLE and ACTIVE:
  - IDLE -> ACTIVE on any rx_valid, accepted or dropped; timer <= 0.
  - In ACTIVE, rx_valid restarts the timer (timer <= 0). Otherwise timer <= timer+1.
  - ACTIVE with timer == TIMEOUT_CYC-1 and no rx_valid -> IDLE, and eom <= 1 for exactly one cycle.
  - rx_valid on that same cycle wins: the FSM stays in ACTIVE, timer <= 0, no eom.
  - Resulting timing: eom is high for the cycle following edge N+TIMEOUT_CYC after the last rx_valid at edge N.
  - idle = (state == IDLE).
  - eom is independent of FIFO state. It fires even if the bytes have already been popped or were dropped.
- Timer width is $clog2(TIMEOUT_CYC). The timer never exceeds TIMEOUT_CYC-1.

Decomposition:
- Shared package uart_pkg holds:
  - the state typedef (IDLE, ACTIVE);
  - a default-timeout function, 10*CLK_FREQ/BAUD_RATE;
  - the common CLK_FREQ/BAUD_RATE defaults shared with the receiver.
- One sub-module, uart_rx_fifo: the synchronous FWFT FIFO with push/pop/level/full/empty.
- The controller top holds the overflow flag and the timeout FSM.

Test Plan:
- Reset: assert reset 2 cycles mid-stream with 3 bytes buffered -> m_valid=0, level=0, overflow=0, idle=1, eom=0; no stale data appears after release.
- Ordering: push 0x11, 0x22, 0x33 with m_ready=0 -> level=3, m_data=0x11; then m_ready=1 -> 0x11, 0x22, 0x33 popped on consecutive cycles, then m_valid=0.
- Overflow: 9 bytes 0x00..0x08 with m_ready=0 (DEPTH=8) -> level=8, 0x08 dropped, overflow=1. Drain yields 0x00..0x07. clr_overflow -> 0. A drop concurrent with clr -> overflow stays 1.
- Full with simultaneous push/pop: FIFO full, rx_valid=0xAA with m_ready=1 -> level stays 8, 0xAA emerges last, overflow stays 0.
- Timeout (TIMEOUT_CYC=20): byte at edge 0, no further bytes -> eom high only in the cycle after edge 20, then idle=1. A second byte at edge 10 moves eom to the cycle after edge 30.
- Boundary: rx_valid exactly at timer==19 -> no eom, FSM stays ACTIVE; eom appears 20 cycles later.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state type, clock/baud defaults and the
// default message-timeout derivation used by the receive controller.
package uart_pkg;

    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD_RATE = 115_200;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } rx_state_t;

    // Ten bit-times (start + 8 data + stop) expressed in clock cycles.
    function automatic int default_timeout(input int clk_freq, input int baud);
        return (10 * clk_freq) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
// The head entry is presented directly from the storage array.
module uart_rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;

    // Storage writes; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign level   = count;
    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: buffers receiver byte strobes into a stream FIFO,
// flags dropped bytes, and signals end-of-message after line idleness.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = default_timeout(CLK_FREQ, BAUD_RATE)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_valid,
    input  logic [DATA_W-1:0]          rx_data,
    output logic                       m_valid,
    output logic [DATA_W-1:0]          m_data,
    input  logic                       m_ready,
    output logic                       eom,
    output logic                       idle,
    output logic                       overflow,
    input  logic                       clr_overflow,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;

    rx_state_t     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          eom_q,   eom_d;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign m_valid = ~fifo_empty;
    assign pop     = m_valid & m_ready;
    assign push    = rx_valid & (~fifo_full | pop);

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (rx_data),
        .pop       (pop),
        .rd_data   (m_data),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sticky drop flag; a new drop outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= (rx_valid & ~push) | (overflow & ~clr_overflow);
        end
    end

    // Idle-timer state machine: every strobe (kept or dropped) restarts the timer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        eom_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    state_d = ACTIVE;
                    timer_d = '0;
                end
            end
            ACTIVE: begin
                if (rx_valid) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = IDLE;
                    timer_d = '0;
                    eom_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // State, timer and end-of-message pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            eom_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            eom_q   <= eom_d;
        end
    end

    assign eom  = eom_q;
    assign idle = (state_q == IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a queue-based reference model.
module tb_uart_rx_ctrl;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;
    localparam int T      = 20;
    localparam int LW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic              eom;
    logic              idle;
    logic              overflow;
    logic              clr_overflow;
    logic [LW-1:0]     level;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue, sticky flag, and message timing by cycle index.
    logic [DATA_W-1:0] mq [$];
    bit                m_ovf    = 0;
    bit                m_active = 0;
    bit                m_eom    = 0;
    int                m_cyc    = 0;
    int                m_last   = 0;

    uart_rx_ctrl #(
        .DEPTH       (DEPTH),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .eom          (eom),
        .idle         (idle),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .level        (level)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit c);
        rx_valid     = v;
        rx_data      = d;
        m_ready      = r;
        clr_overflow = c;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic tick();
        bit pop_m;
        bit acc;
        if (reset) begin
            mq.delete();
            m_ovf    = 0;
            m_active = 0;
            m_eom    = 0;
        end else begin
            pop_m = (mq.size() > 0) && m_ready;
            acc   = rx_valid && ((mq.size() < DEPTH) || pop_m);
            if (pop_m) void'(mq.pop_front());
            if (acc) mq.push_back(rx_data);
            m_ovf = (rx_valid && !acc) || (m_ovf && !clr_overflow);
            m_eom = 0;
            if (rx_valid) begin
                m_active = 1;
                m_last   = m_cyc;
            end else if (m_active && (m_cyc - m_last) == T) begin
                m_eom    = 1;
                m_active = 0;
            end
        end
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'hA1 + 8'(i), 0, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        checks++;
        if (level !== LW'(3)) begin
            errors++; $display("FAIL rst_prefill_level got %0d want 3", level);
        end
        reset = 1;
        drive(1, 8'hEE, 0, 0);
        tick();
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %0b want 0", m_valid); end
        checks++; if (level !== '0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %0b want 0", overflow); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %0b want 1", idle); end
        checks++; if (eom !== 1'b0) begin errors++; $display("FAIL rst_eom got %0b want 0", eom); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL rst_m_data got %h want 00", m_data); end
        reset = 0;
        drive(0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (m_valid !== 1'b0 || level !== '0) begin
                errors++; $display("FAIL rst_stale valid=%0b level=%0d want 0/0", m_valid, level);
            end
        end
    endtask

    task automatic test_ordering();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            drive(1, exp_b[i], 0, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        checks++; if (level !== LW'(3)) begin errors++; $display("FAIL ord_level got %0d want 3", level); end
        checks++; if (m_data !== 8'h11) begin errors++; $display("FAIL ord_head got %h want 11", m_data); end
        drive(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_b[i]) begin
                errors++; $display("FAIL ord_pop%0d got %0b/%h want 1/%h", i, m_valid, m_data, exp_b[i]);
            end
            tick();
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ord_empty got %0b want 0", m_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) begin
            drive(1, 8'(i), 0, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        checks++; if (level !== LW'(8)) begin errors++; $display("FAIL ovf_level got %0d want 8", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b want 1", overflow); end
        drive(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (m_data !== 8'(i)) begin errors++; $display("FAIL ovf_drain%0d got %h want %h", i, m_data, 8'(i)); end
            tick();
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %0b want 0", m_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
        drive(0, 0, 0, 1);
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %0b want 0", overflow); end
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'h50 + 8'(i), 0, 0);
            tick();
        end
        drive(1, 8'h99, 0, 1);
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_vs_clr got %0b want 1", overflow); end
        drive(0, 0, 1, 1);
        for (int i = 0; i < 8; i++) tick();
        checks++; if (overflow !== 1'b0 || level !== '0) begin
            errors++; $display("FAIL ovf_final got %0b/%0d want 0/0", overflow, level);
        end
        drive(0, 0, 1, 0);
    endtask

    task automatic test_full_push_pop();
        logic [7:0] want;
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'h40 + 8'(i), 0, 0);
            tick();
        end
        drive(1, 8'hAA, 1, 0);
        tick();
        drive(0, 0, 0, 0);
        checks++; if (level !== LW'(8)) begin errors++; $display("FAIL fpp_level got %0d want 8", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow got %0b want 0", overflow); end
        drive(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            want = (i < 7) ? 8'h41 + 8'(i) : 8'hAA;
            checks++;
            if (m_data !== want) begin errors++; $display("FAIL fpp_drain%0d got %h want %h", i, m_data, want); end
            tick();
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty got %0b want 0", m_valid); end
    endtask

    task automatic settle_idle();
        drive(0, 0, 1, 0);
        for (int k = 0; k < 2 * T && !(idle === 1'b1 && eom === 1'b0); k++) tick();
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL settle_idle got %0b want 1", idle); end
    endtask

    task automatic test_timeout();
        bit want;
        settle_idle();
        drive(1, 8'h5A, 1, 0);
        tick();
        for (int k = 1; k <= 24; k++) begin
            drive(0, 0, 1, 0);
            tick();
            want = (k == T);
            checks++;
            if (eom !== want || m_eom != want) begin errors++; $display("FAIL to_single k=%0d got %0b want %0b", k, eom, want); end
            if (k == T - 1) begin
                checks++; if (idle !== 1'b0) begin errors++; $display("FAIL to_active got %0b want 0", idle); end
            end
            if (k == T + 1) begin
                checks++; if (idle !== 1'b1) begin errors++; $display("FAIL to_idle got %0b want 1", idle); end
            end
        end
        settle_idle();
        drive(1, 8'h5B, 1, 0);
        tick();
        for (int k = 1; k <= 34; k++) begin
            drive(k == 10, 8'h5C, 1, 0);
            tick();
            want = (k == 30);
            checks++;
            if (eom !== want) begin errors++; $display("FAIL to_restart k=%0d got %0b want %0b", k, eom, want); end
        end
    endtask

    task automatic test_boundary();
        bit want;
        settle_idle();
        drive(1, 8'h61, 1, 0);
        tick();
        for (int k = 1; k <= 44; k++) begin
            drive(k == T, 8'h62, 1, 0);
            tick();
            want = (k == 2 * T);
            checks++;
            if (eom !== want) begin errors++; $display("FAIL bnd k=%0d got %0b want %0b", k, eom, want); end
            if (k == T) begin
                checks++; if (idle !== 1'b0) begin errors++; $display("FAIL bnd_stay_active got %0b want 0", idle); end
            end
        end
    endtask

    task automatic test_random();
        int rx_pct;
        int rd_pct;
        for (int i = 0; i < 400; i++) begin
            rx_pct = ((i / 100) % 2 == 0) ? 50 : 4;
            rd_pct = (i < 200) ? 20 : 70;
            drive($urandom_range(0, 99) < rx_pct, 8'($urandom),
                  $urandom_range(0, 99) < rd_pct, $urandom_range(0, 99) < 5);
            tick();
            checks++;
            if (level !== LW'(mq.size())) begin errors++; $display("FAIL rnd_level i=%0d got %0d want %0d", i, level, mq.size()); end
            checks++;
            if (m_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid i=%0d got %0b want %0b", i, m_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                checks++;
                if (m_data !== mq[0]) begin errors++; $display("FAIL rnd_data i=%0d got %h want %h", i, m_data, mq[0]); end
            end
            checks++;
            if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf i=%0d got %0b want %0b", i, overflow, m_ovf); end
            checks++;
            if (eom !== m_eom) begin errors++; $display("FAIL rnd_eom i=%0d got %0b want %0b", i, eom, m_eom); end
            checks++;
            if (idle !== !m_active) begin errors++; $display("FAIL rnd_idle i=%0d got %0b want %0b", i, idle, !m_active); end
        end
        drive(0, 0, 0, 0);
    endtask

    initial begin
        reset = 1;
        drive(0, 0, 0, 0);
        tick();
        tick();
        reset = 0;
        test_reset();
        test_ordering();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_boundary();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
